// File: rtl/alsu_display_ctrl_pkg.sv
// Shared definitions for the ALSU display sequencer: state encoding, result width, 100 MHz timing defaults.
package alsu_display_ctrl_pkg;

    localparam int unsigned RES_W           = 6;
    localparam int unsigned DEF_HOLD_CYCLES = 100_000_000;  // 1 s at 100 MHz
    localparam int unsigned DEF_ERR_CYCLES  = 200_000_000;  // 2 s at 100 MHz
    localparam int unsigned DEF_CNT_W       = 28;

    // 2'd3 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW_RES = 2'd1,
        SHOW_ERR = 2'd2
    } state_e;

endpackage

// File: rtl/alsu_display_ctrl_result_fifo.sv
// Small result buffer: DEPTH entries, wrapping pointers, occupancy count 0..DEPTH.
module alsu_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == OCC_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed since entries are only read when valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/alsu_display_ctrl.sv
// Sequences buffered ALSU results onto the 7-segment driver with hold and error windows.
module alsu_display_ctrl
    import alsu_display_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned ERR_CYCLES  = DEF_ERR_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clock_100Mhz,
    input  logic             reset,
    input  logic             res_valid,
    input  logic [RES_W-1:0] res_data,
    output logic             res_ready,
    input  logic             err_req,
    input  logic             freeze,
    output logic             disp_valid,
    output logic [RES_W-1:0] disp_data,
    output logic             busy
);

    localparam int unsigned     FCNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_LOAD  = CNT_W'(ERR_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               disp_valid_q, disp_valid_d;
    logic [RES_W-1:0]   disp_data_q, disp_data_d;
    logic               busy_q, busy_d;
    logic               push_c, pop_c, expiry_c;
    logic [RES_W-1:0]   fifo_dout;
    logic               fifo_full, fifo_empty;
    logic [FCNT_W-1:0]  fifo_count;

    assign res_ready  = !fifo_full;
    assign push_c     = res_valid && !fifo_full;
    assign expiry_c   = (cnt_q == '0) && !freeze;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign busy       = busy_q;

    // Result buffer, accepts in every state while not full
    alsu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk   (clock_100Mhz),
        .rst_n (reset),
        .push  (push_c),
        .pop   (pop_c),
        .din   (res_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state, counter and display decisions; err_req always beats expiry
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        disp_valid_d = disp_valid_q;
        disp_data_d  = disp_data_q;
        pop_c        = 1'b0;
        if (!freeze && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);

        case (state_q)
            IDLE: begin
                disp_valid_d = 1'b1;
                if (err_req) begin
                    state_d      = SHOW_ERR;
                    cnt_d        = ERR_LOAD;
                    disp_valid_d = 1'b0;
                end else if (!fifo_empty) begin
                    pop_c       = 1'b1;
                    disp_data_d = fifo_dout;
                    cnt_d       = HOLD_LOAD;
                    state_d     = SHOW_RES;
                end
            end
            SHOW_RES: begin
                disp_valid_d = 1'b1;
                if (err_req) begin
                    state_d      = SHOW_ERR;
                    cnt_d        = ERR_LOAD;
                    disp_valid_d = 1'b0;
                end else if (expiry_c) begin
                    if (!fifo_empty) begin
                        pop_c       = 1'b1;
                        disp_data_d = fifo_dout;
                        cnt_d       = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SHOW_ERR: begin
                disp_valid_d = 1'b0;
                if (err_req) begin
                    cnt_d = ERR_LOAD;
                end else if (expiry_c) begin
                    disp_valid_d = 1'b1;
                    if (!fifo_empty) begin
                        pop_c       = 1'b1;
                        disp_data_d = fifo_dout;
                        cnt_d       = HOLD_LOAD;
                        state_d     = SHOW_RES;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                disp_valid_d = 1'b1;
            end
        endcase

        // Busy reflects the state and occupancy that will exist after this edge
        busy_d = (state_d != IDLE) || push_c || (fifo_count > FCNT_W'(pop_c));
    end

    // State and output registers
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            disp_valid_q <= 1'b1;
            disp_data_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_alsu_display_ctrl.sv
// Bench for alsu_display_ctrl: queue-based display model checked every cycle plus directed literal checks.
module tb_alsu_display_ctrl;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int ERR   = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       res_valid = 1'b0;
    logic [5:0] res_data = '0;
    logic       err_req = 1'b0;
    logic       freeze = 1'b0;
    logic       res_ready, disp_valid, busy;
    logic [5:0] disp_data;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: what is on screen, how long it has been there, and what is waiting
    int         m_mode = 0;     // 0 idle, 1 showing a result, 2 showing error
    int         m_elapsed = 0;  // unfrozen clocks already spent in the current window
    logic [5:0] m_shown = '0;
    logic [5:0] m_q[$];

    alsu_display_ctrl #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .ERR_CYCLES  (ERR),
        .CNT_W       (28)
    ) dut (
        .clock_100Mhz (clk),
        .reset        (reset),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_ready    (res_ready),
        .err_req      (err_req),
        .freeze       (freeze),
        .disp_valid   (disp_valid),
        .disp_data    (disp_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit   ready;
        bit   last;
        int   lim;
        if (!reset) begin
            m_mode = 0; m_elapsed = 0; m_shown = '0; m_q.delete();
        end else begin
            ready = (m_q.size() != DEPTH);
            lim   = (m_mode == 2) ? ERR : HOLD;
            last  = (m_mode != 0) && (m_elapsed + 1 == lim) && !freeze;
            if (err_req) begin
                m_mode = 2; m_elapsed = 0;
            end else if (m_mode == 0) begin
                if (m_q.size() > 0) begin
                    m_shown = m_q.pop_front(); m_mode = 1; m_elapsed = 0;
                end
            end else if (last) begin
                if (m_q.size() > 0) begin
                    m_shown = m_q.pop_front(); m_mode = 1; m_elapsed = 0;
                end else begin
                    m_mode = 0;
                end
            end else if (!freeze) begin
                m_elapsed++;
            end
            if (res_valid && ready) m_q.push_back(res_data);
        end
    endtask

    // Advance the model on each clock and on reset assertion
    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("disp_valid", int'(disp_valid), (m_mode != 2) ? 1 : 0);
        chk("disp_data",  int'(disp_data),  int'(m_shown));
        chk("res_ready",  int'(res_ready),  (m_q.size() != DEPTH) ? 1 : 0);
        chk("busy",       int'(busy),       (m_mode != 0 || m_q.size() != 0) ? 1 : 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_disp_valid", int'(disp_valid), 1);
        chk("rst_disp_data",  int'(disp_data),  0);
        chk("rst_res_ready",  int'(res_ready),  1);
        chk("rst_busy",       int'(busy),       0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_disp_valid", int'(disp_valid), 1);

        // Single result: latency and hold length
        res_valid = 1'b1; res_data = 6'h15;
        @(negedge clk); res_valid = 1'b0;
        chk("lat_not_yet", int'(disp_data), 0);
        @(negedge clk);
        chk("lat_shown", int'(disp_data), 'h15);
        n = 0;
        while (busy && n < 20) begin n++; @(negedge clk); end
        chk("hold_len", n, 4);
        chk("idle_keeps_last", int'(disp_data), 'h15);

        // Fill the buffer while frozen, then drain back-to-back
        freeze = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            res_valid = 1'b1; res_data = 6'(i);
            @(negedge clk);
        end
        res_valid = 1'b0;
        chk("full_not_ready", int'(res_ready), 0);
        chk("first_shown", int'(disp_data), 1);
        repeat (2) @(negedge clk);
        chk("frozen_hold", int'(disp_data), 1);
        freeze = 1'b0;
        n = 0;
        while (disp_data != 6'h02 && n < 20) begin @(negedge clk); n++; end
        chk("unfreeze_to_02", n, 4);
        chk("ready_after_pop", int'(res_ready), 1);
        for (int v = 2; v <= 5; v++) begin
            int m;
            m = 0;
            while (disp_data == 6'(v) && busy && m < 20) begin m++; @(negedge clk); end
            chk("b2b_hold", m, 4);
        end
        chk("drain_idle", int'(busy), 0);
        chk("drain_last", int'(disp_data), 5);

        // Error pre-empts a result with one buffered
        res_valid = 1'b1; res_data = 6'h2A;
        @(negedge clk); res_data = 6'h11;
        @(negedge clk); res_valid = 1'b0;
        chk("show_2a", int'(disp_data), 'h2A);
        @(negedge clk);
        err_req = 1'b1;
        @(negedge clk); err_req = 1'b0;
        n = 0;
        while (!disp_valid && n < 20) begin n++; @(negedge clk); end
        chk("err_window", n, 6);
        chk("after_err_11", int'(disp_data), 'h11);
        n = 0;
        while (busy && n < 20) begin n++; @(negedge clk); end
        chk("no_reshow_2a", int'(disp_data), 'h11);

        // Restart of the error window at its 4th clock
        err_req = 1'b1;
        @(negedge clk); err_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_4th_clock", int'(disp_valid), 0);
        err_req = 1'b1;
        @(negedge clk); err_req = 1'b0;
        n = 0;
        while (!disp_valid && n < 20) begin n++; @(negedge clk); end
        chk("err_restart_total", 4 + n, 10);

        // err_req on the expiry cycle restarts the window
        err_req = 1'b1;
        @(negedge clk); err_req = 1'b0;
        repeat (5) @(negedge clk);
        err_req = 1'b1;
        @(negedge clk); err_req = 1'b0;
        n = 0;
        while (!disp_valid && n < 20) begin n++; @(negedge clk); end
        chk("err_vs_expiry", n, 6);

        // Freeze extends the hold by exactly the frozen clocks
        res_valid = 1'b1; res_data = 6'h33;
        @(negedge clk); res_valid = 1'b0;
        @(negedge clk);
        chk("show_33", int'(disp_data), 'h33);
        n = 0;
        while (busy && n < 40) begin
            n++;
            freeze = (n < 11);
            @(negedge clk);
        end
        freeze = 1'b0;
        chk("freeze_extend", n, 14);

        // A push during the error window is shown afterwards
        err_req = 1'b1;
        @(negedge clk); err_req = 1'b0;
        @(negedge clk);
        res_valid = 1'b1; res_data = 6'h0C;
        @(negedge clk); res_valid = 1'b0;
        chk("push_in_err", int'(disp_valid), 0);
        n = 0;
        while (!disp_valid && n < 20) begin n++; @(negedge clk); end
        chk("shown_after_err", int'(disp_data), 'h0C);
        n = 0;
        while (busy && n < 20) begin n++; @(negedge clk); end

        // Reset mid-SHOW_RES with results buffered
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_data = 6'(6'h3F - 6'(i * 'h1C));
            @(negedge clk);
        end
        res_valid = 1'b0;
        chk("pre_reset_shown", int'(disp_data), 'h3F);
        #2 reset = 1'b0;
        #1;
        chk("midrst_disp_valid", int'(disp_valid), 1);
        chk("midrst_disp_data",  int'(disp_data),  0);
        chk("midrst_res_ready",  int'(res_ready),  1);
        chk("midrst_busy",       int'(busy),       0);
        @(negedge clk);
        reset = 1'b1; freeze = 1'b0;
        repeat (8) @(negedge clk);
        chk("buffer_lost_busy", int'(busy), 0);
        chk("buffer_lost_data", int'(disp_data), 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
